guess_game_ctrl: RTL and testbench

Round sequencer for the button guessing game.
- Generates the slow step enable (`tick`) that advances the guess FSM's rotating LED pattern.
- Synchronises and edge-detects the four raw buttons and clears the guess FSM between rounds.
- Holds the win/lose indication for a fixed time and keeps score over a fixed number of rounds.
- Sits between the board I/O and the guess FSM instance.

---
 rtl/guess_game_ctrl.sv | 137 +++++++++++++
 tb/tb_guess_game_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Round sequencer for the button guessing game: conditions the raw buttons, paces the
// guess FSM with a divided step enable, holds the round result and keeps score per game.
module guess_game_ctrl #(
    parameter int N      = 4,
    parameter int HOLD   = 8,
    parameter int ROUNDS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       b0,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       win_in,
    input  logic       lose_in,
    output logic       tick,
    output logic       guess_clr,
    output logic [3:0] bp,
    output logic [3:0] score,
    output logic [2:0] round,
    output logic       led_win,
    output logic       led_lose,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLAY,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_ROUND = 3'(ROUNDS - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);

    state_t       state;
    state_t       state_next;
    logic [4:0]   raw;
    logic [4:0]   sync1;
    logic [4:0]   sync2;
    logic [4:0]   prev;
    logic [4:0]   edges;
    logic [3:0]   btn_edge;
    logic         start_edge;
    logic         one_press;
    logic [N-1:0] div;
    logic         itick;
    logic [7:0]   hold_cnt;
    logic         hold_done;

    // Bit 4 is start, bits 3..0 are the guess buttons.
    assign raw        = {start, b3, b2, b1, b0};
    assign edges      = sync2 & ~prev;
    assign btn_edge   = edges[3:0];
    assign start_edge = edges[4];
    assign one_press  = (btn_edge != 4'd0) && ((btn_edge & (btn_edge - 4'd1)) == 4'd0);
    assign itick      = &div;
    assign hold_done  = (state == S_HOLD) && itick && (hold_cnt == HOLD_LAST);

    assign tick      = itick && (state == S_PLAY);
    assign guess_clr = (state == S_CLEAR);
    assign done      = (state == S_DONE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_edge) state_next = S_CLEAR;
            S_CLEAR: state_next = S_PLAY;
            S_PLAY:  if (win_in || lose_in) state_next = S_HOLD;
            S_HOLD:  if (hold_done) state_next = (round == LAST_ROUND) ? S_DONE : S_CLEAR;
            S_DONE:  if (start_edge) state_next = S_CLEAR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            bp       <= '0;
            div      <= '0;
            hold_cnt <= '0;
            score    <= '0;
            round    <= '0;
            led_win  <= 1'b0;
            led_lose <= 1'b0;
        end else begin
            state <= state_next;
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
            bp    <= ((state == S_PLAY) && one_press) ? btn_edge : 4'd0;

            // The divider restarts on PLAY and HOLD entry so both phases see full tick periods.
            if ((state_next != state) && ((state_next == S_PLAY) || (state_next == S_HOLD)))
                div <= '0;
            else
                div <= div + 1'b1;

            if (state != S_HOLD)
                hold_cnt <= '0;
            else if (itick)
                hold_cnt <= (hold_cnt == HOLD_LAST) ? 8'd0 : hold_cnt + 8'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        score <= '0;
                        round <= '0;
                    end
                end
                S_PLAY: begin
                    if (win_in) begin
                        led_win <= 1'b1;
                        score   <= (score == 4'hF) ? 4'hF : score + 4'd1;
                    end else if (lose_in) begin
                        led_lose <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_done) begin
                        led_win  <= 1'b0;
                        led_lose <= 1'b0;
                        if (round != LAST_ROUND)
                            round <= round + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Bench for guess_game_ctrl: games are planned up front from the game rules, expected
// output events are queued with their cycle stamps, and a negedge monitor matches them.
module tb_guess_game_ctrl;

    localparam int N      = 2;
    localparam int HOLD   = 2;
    localparam int ROUNDS = 3;
    localparam int P      = 1 << N;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] btn;
    logic       win_in;
    logic       lose_in;
    logic       tick;
    logic       guess_clr;
    logic [3:0] bp;
    logic [3:0] score;
    logic [2:0] round;
    logic       led_win;
    logic       led_lose;
    logic       done;

    guess_game_ctrl #(.N(N), .HOLD(HOLD), .ROUNDS(ROUNDS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .b0(btn[0]), .b1(btn[1]), .b2(btn[2]), .b3(btn[3]),
        .win_in(win_in), .lose_in(lose_in),
        .tick(tick), .guess_clr(guess_clr), .bp(bp), .score(score), .round(round),
        .led_win(led_win), .led_lose(led_lose), .done(done)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [38:0] clr_q[$];     // {stamp, round, score}
    logic [31:0] tick_q[$];    // stamp
    logic [35:0] bp_q[$];      // {stamp, pattern}
    logic [39:0] led_q[$];     // {stamp, win, score, round}
    logic [31:0] fall_q[$];    // stamp
    logic [38:0] done_q[$];    // {stamp, round, score}
    logic [31:0] undone_q[$];  // stamp
    bit in_done = 0;
    int game_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_win = 1'b0, prev_lose = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        logic [39:0] e;
        check("led_exclusive", {63'd0, led_win & led_lose}, 64'd0);
        if (guess_clr === 1'b1) begin
            if (clr_q.size() == 0) check("clr_unexpected", {63'd0, guess_clr}, 64'd0);
            else begin
                e = {1'b0, clr_q.pop_front()};
                check("clr_cycle", cyc, e[38:7]);
                check("clr_round", round, e[6:4]);
                check("clr_score", score, e[3:0]);
            end
        end
        if (tick === 1'b1) begin
            if (tick_q.size() == 0) check("tick_unexpected", {63'd0, tick}, 64'd0);
            else check("tick_cycle", cyc, tick_q.pop_front());
        end
        if (bp !== 4'd0 && !$isunknown(bp)) begin
            if (bp_q.size() == 0) check("bp_unexpected", bp, 64'd0);
            else begin
                e = {4'd0, bp_q.pop_front()};
                check("bp_cycle", cyc, e[35:4]);
                check("bp_value", bp, e[3:0]);
            end
        end
        if ((led_win || led_lose) && !(prev_win || prev_lose)) begin
            if (led_q.size() == 0) check("led_unexpected", {led_win, led_lose}, 64'd0);
            else begin
                e = led_q.pop_front();
                check("led_cycle", cyc, e[39:8]);
                check("led_win", led_win, e[7]);
                check("led_lose", led_lose, !e[7]);
                check("led_score", score, e[6:3]);
                check("led_round", round, e[2:0]);
            end
        end
        if (!(led_win || led_lose) && (prev_win || prev_lose)) begin
            if (fall_q.size() == 0) check("led_fall_unexpected", cyc, 64'd0);
            else check("led_fall_cycle", cyc, fall_q.pop_front());
        end
        if (done === 1'b1 && !prev_done) begin
            if (done_q.size() == 0) check("done_unexpected", {63'd0, done}, 64'd0);
            else begin
                e = {1'b0, done_q.pop_front()};
                check("done_cycle", cyc, e[38:7]);
                check("done_round", round, e[6:4]);
                check("done_score", score, e[3:0]);
            end
        end
        if (done === 1'b0 && prev_done) begin
            if (undone_q.size() == 0) check("done_fall_unexpected", cyc, 64'd0);
            else check("done_fall_cycle", cyc, undone_q.pop_front());
        end
        prev_win  = (led_win === 1'b1);
        prev_lose = (led_lose === 1'b1);
        prev_done = (done === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic [3:0] rand_press();
        int i1, i2;
        logic [3:0] pat;
        if ($urandom_range(0, 3) == 0) begin
            i1  = $urandom_range(0, 3);
            i2  = (i1 + $urandom_range(1, 3)) % 4;
            pat = 4'(1 << i1) | 4'(1 << i2);
        end else begin
            pat = 4'(1 << $urandom_range(0, 3));
        end
        return pat;
    endfunction

    // Outcome codes: 0 lose, 1 win, 2 win and lose together, -1 random.
    // abort_r >= 0 pulses reset during that round's lose/win display.
    task automatic run_game(input int abort_r, input int oc0, input int oc1, input int oc2,
                            output int end_c);
        int oc[ROUNDS];
        int p[ROUNDS];
        int w[ROUNDS];
        logic [3:0] pat[ROUNDS][3];
        int d, sc, h, nr;
        bit win;
        oc = '{oc0, oc1, oc2};
        nr = (abort_r < 0) ? ROUNDS : abort_r + 1;
        d  = cyc;
        sc = 0;
        end_c = 0;
        p[0] = d + 4;
        clr_q.push_back({32'(d + 3), 3'd0, 4'd0});
        if (in_done) undone_q.push_back(32'(d + 3));
        for (int r = 0; r < nr; r++) begin
            if (oc[r] < 0) oc[r] = $urandom_range(0, 2);
            w[r] = p[r] + $urandom_range(12, 20);
            for (int t = p[r] + P - 1; t <= w[r]; t += P) tick_q.push_back(32'(t));
            for (int i = 0; i < 3; i++) begin
                pat[r][i] = rand_press();
                if (game_no == 1 && r == 0 && i == 0) pat[r][i] = 4'b0100;
                if (game_no == 1 && r == 0 && i == 1) pat[r][i] = 4'b0011;
                if ($countones(pat[r][i]) == 1)
                    bp_q.push_back({32'(p[r] + 1 + 4 * i + 3), pat[r][i]});
            end
            win = (oc[r] != 0);
            if (win) sc = (sc < 15) ? sc + 1 : 15;
            h = w[r] + 1;
            led_q.push_back({32'(h), win, 4'(sc), 3'(r)});
            if (r == abort_r) begin
                fall_q.push_back(32'(w[r] + 4));
                end_c = w[r] + 5;
            end else begin
                fall_q.push_back(32'(h + P * HOLD));
                if (r < ROUNDS - 1) begin
                    clr_q.push_back({32'(h + P * HOLD), 3'(r + 1), 4'(sc)});
                    p[r + 1] = h + P * HOLD + 1;
                end else begin
                    done_q.push_back({32'(h + P * HOLD), 3'(r), 4'(sc)});
                    end_c = h + P * HOLD;
                end
            end
        end

        start = 1'b1;
        wait_until(d + 2); start = 1'b0;
        for (int r = 0; r < nr; r++) begin
            wait_until(p[r] + 1);  btn = pat[r][0];
            wait_until(p[r] + 2);  start = 1'b1;
            wait_until(p[r] + 3);  btn = 4'd0;
            wait_until(p[r] + 4);  start = 1'b0;
            wait_until(p[r] + 5);  btn = pat[r][1];
            wait_until(p[r] + 7);  btn = 4'd0;
            wait_until(p[r] + 9);  btn = pat[r][2];
            wait_until(p[r] + 11); btn = 4'd0;
            wait_until(w[r]);
            win_in  = (oc[r] != 0);
            lose_in = (oc[r] != 1);
            wait_until(w[r] + 1);  win_in = 1'b0; lose_in = 1'b0;
            if (r == abort_r) begin
                wait_until(w[r] + 3); reset = 1'b1;
                wait_until(w[r] + 5); reset = 1'b0;
            end else begin
                // Result inputs and start while the result is shown must be ignored.
                wait_until(w[r] + 3); win_in = 1'b1; lose_in = 1'b1; start = 1'b1;
                wait_until(w[r] + 4); win_in = 1'b0; lose_in = 1'b0;
                wait_until(w[r] + 5); start = 1'b0;
            end
        end
        in_done = (abort_r < 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int end_c;
        reset = 1'b1; start = 1'b0; btn = 4'd0; win_in = 1'b0; lose_in = 1'b0;
        @(negedge clk); btn = 4'b1011;
        @(negedge clk); btn = 4'b0110;
        check("reset_outputs", {tick, guess_clr, bp, score, round, led_win, led_lose, done}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn = 4'($urandom_range(0, 15));
            lose_in = 1'($urandom_range(0, 1));
        end
        btn = 4'd0; lose_in = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_outputs", {tick, guess_clr, bp, score, round, led_win, led_lose, done}, 64'd0);

        game_no = 1;
        run_game(-1, 2, 0, 1, end_c);
        wait_until(end_c + 3);
        check("game1_final", {done, score, round}, {1'b1, 4'd2, 3'd2});
        repeat (6) @(negedge clk);

        game_no = 2;
        run_game(-1, -1, -1, -1, end_c);
        wait_until(end_c + 3 + $urandom_range(0, 5));

        game_no = 3;
        run_game(1, 1, 0, 0, end_c);
        wait_until(end_c);
        check("after_reset_outputs",
              {tick, guess_clr, bp, score, round, led_win, led_lose, done}, 64'd0);
        repeat (20) @(negedge clk);
        check("idle_after_reset", {score, round, done}, 64'd0);

        check("clr_q_left", clr_q.size(), 64'd0);
        check("tick_q_left", tick_q.size(), 64'd0);
        check("bp_q_left", bp_q.size(), 64'd0);
        check("led_q_left", led_q.size(), 64'd0);
        check("fall_q_left", fall_q.size(), 64'd0);
        check("done_q_left", done_q.size(), 64'd0);
        check("undone_q_left", undone_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
